tail_light_seq: RTL and testbench
=================================

# tail_light_seq

Parametrised rear-lamp sequencer for the car lighting path: drives N_LED lamps per side with a sequential-fill turn indication, brake override and hazard blink. It generalises the fixed 3-lamp, one-step-per-clock controller with three additions: lamp count set by parameter, animation rate set by an internal prescaler, and a decoded mode output. It sits between the driver-input debouncers and the lamp drivers.

## Interface
- N_LED, default 3: lamps per side, legal range 1..16.
- STEP_DIV, default 1: clock cycles per animation step (turn fill and hazard toggle), legal range 1..65535.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately. Release is synchronous to clk on the next edge.
- emergency  in  1  hazard request, highest priority.
- left  in  1  left turn request.
- right  in  1  right turn request.
- brake  in  1  brake pedal.
- led_left  out  N_LED  left lamps. Bit 0 is the innermost lamp.
- led_right  out  N_LED  right lamps. Bit 0 is the innermost lamp.
- mode  out  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.

## Operation
- State registers:
  - mode (2 bits)
  - brake_q
  - prescaler cnt, width clog2(STEP_DIV), minimum 1
  - step, 0..N_LED, width clog2(N_LED+1)
  - phase (1 bit)
- Mode decode, sampled every rising edge:
  - emergency=1 → HAZARD.
  - Otherwise left=1 and right=0 → LEFT.
  - Otherwise right=1 and left=0 → RIGHT.
  - Otherwise → IDLE. This includes left=right=1, which is an illegal combination treated as no turn.
- brake_q <= brake every edge. It is independent of mode.
- On a mode change (decoded mode differs from the registered mode): cnt<=0, step<=0, phase<=1.
- With mode unchanged and mode ≠ IDLE:
  - cnt increments each cycle.
  - When cnt==STEP_DIV-1 (a tick): cnt<=0, and step/phase advance.
- In IDLE: cnt, step and phase are held at 0/0/1.
- Step advance (LEFT/RIGHT): step <= (step==N_LED) ? 0 : step+1.
- Phase advance (HAZARD): phase <= ~phase.
- Lamp pattern, a function of the registered state only (no combinational input path). THERM(k) = the low k bits set.
  - IDLE: both sides = brake_q ? all-ones : 0.
  - LEFT: led_left = THERM(step); led_right = brake_q ? all-ones : 0.
  - RIGHT: mirror of LEFT.
  - HAZARD: both sides = phase ? all-ones : 0. Brake is ignored.
- A change of brake never restarts or pauses the animation.

## Timing
- Reset values: led_left=0, led_right=0, mode=0, cnt=0, step=0, phase=1, brake_q=0.
- Latency: an input change sampled at edge n is visible on mode and the leds after edge n. This is one register stage.
- Entering LEFT at edge n:
  - left lamps = 0 after edge n.
  - THERM(1) after edge n+STEP_DIV.
  - THERM(N_LED) after edge n+N_LED·STEP_DIV.
  - 0 again after edge n+(N_LED+1)·STEP_DIV.
  - The full period is (N_LED+1)·STEP_DIV cycles.
- Entering HAZARD at edge n:
  - all-on after edge n.
  - all-off after edge n+STEP_DIV.
  - The period is 2·STEP_DIV cycles with 50% duty.
- STEP_DIV=1: one step per clock, with no idle cycles.
- Switching LEFT→RIGHT directly restarts RIGHT at step 0. The left side drops to the brake pattern on the same edge.
- Simultaneous emergency and turn: HAZARD wins. When emergency drops while the turn is still held, LEFT/RIGHT restarts at step 0.
- Asserting reset mid-animation clears the lamps asynchronously, with no wait for clk. After release, the first edge decodes the inputs as a fresh mode change.

## Test plan
- N_LED=3, STEP_DIV=1, reset released, left=1 held → led_left cycles 000,001,011,111,000 on consecutive clocks; led_right=000; mode=1.
- N_LED=4, STEP_DIV=3, right=1 and brake=1 → led_left=1111 constant; led_right steps 0000→0001→0011→0111→1111→0000, each value held exactly 3 clocks.
- N_LED=3, STEP_DIV=2, emergency=1 with left=1 and brake=1 → mode=3; both sides 111,111,000,000,111 repeating, brake ignored. Emergency released → mode=1, led_left=000, led_right=111.
- left=right=1, brake=0 → mode=0, both sides 0. Add brake=1 → both sides all-ones one edge later.
- Mid-fill (led_left=011), switch to right=1 → next edge led_left=000, led_right=000, mode=2, then led_right advances 001 after STEP_DIV clocks.
- Assert reset (0) between clock edges during a hazard-on phase → leds=0, mode=0 before the next edge. Release with emergency=1 → all-on after the first edge.

Source files
------------

// File: rtl/tail_light_seq_if.sv
// Request/lamp bundle between the driver-input debouncers and the lamp drivers.
// The design end uses the slave modport and the input side uses the master modport.
interface tail_light_seq_if #(
  parameter int unsigned N_LED = 3
) ();
  logic             emergency;
  logic             left;
  logic             right;
  logic             brake;
  logic [N_LED-1:0] led_left;
  logic [N_LED-1:0] led_right;
  logic [1:0]       mode;

  modport master (
    output emergency, left, right, brake,
    input  led_left, led_right, mode
  );

  modport slave (
    input  emergency, left, right, brake,
    output led_left, led_right, mode
  );
endinterface

// File: rtl/tail_light_seq.sv
// Rear-lamp sequencer: sequential-fill turn indication, brake override and hazard blink,
// with a parametrised lamp count and a prescaled animation rate.
module tail_light_seq #(
  parameter int unsigned N_LED    = 3,
  parameter int unsigned STEP_DIV = 1
) (
  input logic             clk,
  input logic             reset,
  tail_light_seq_if.slave bus
);
  localparam int unsigned CNT_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned STEP_W = $clog2(N_LED + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_e;

  mode_e             mode_q, mode_d;
  logic              brake_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              phase_q, phase_d;
  logic              tick;
  logic [N_LED-1:0]  therm, brake_pat, hazard_pat, led_l, led_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= IDLE;
      brake_q <= 1'b0;
      cnt_q   <= '0;
      step_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      mode_q  <= mode_d;
      brake_q <= bus.brake;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      phase_q <= phase_d;
    end
  end

  assign tick = (cnt_q == CNT_W'(STEP_DIV - 1));

  always_comb begin
    mode_d  = IDLE;
    cnt_d   = '0;
    step_d  = '0;
    phase_d = 1'b1;

    if (bus.emergency)                mode_d = HAZARD;
    else if (bus.left && !bus.right)  mode_d = LEFT;
    else if (bus.right && !bus.left)  mode_d = RIGHT;

    // A mode change or IDLE restarts the animation from its initial state.
    if (mode_d == mode_q && mode_q != IDLE) begin
      cnt_d   = cnt_q + 1'b1;
      step_d  = step_q;
      phase_d = phase_q;
      if (tick) begin
        cnt_d = '0;
        if (mode_q == HAZARD) phase_d = ~phase_q;
        else                  step_d  = (step_q == STEP_W'(N_LED)) ? '0 : step_q + 1'b1;
      end
    end
  end

  always_comb begin
    therm = '0;
    for (int unsigned i = 0; i < N_LED; i++) therm[i] = (i < 32'(step_q));
    brake_pat  = {N_LED{brake_q}};
    hazard_pat = {N_LED{phase_q}};
    led_l      = brake_pat;
    led_r      = brake_pat;
    case (mode_q)
      LEFT:    led_l = therm;
      RIGHT:   led_r = therm;
      HAZARD: begin
        led_l = hazard_pat;
        led_r = hazard_pat;
      end
      default: ;
    endcase
  end

  assign bus.led_left  = led_l;
  assign bus.led_right = led_r;
  assign bus.mode      = mode_q;
endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: three parameterisations share one stimulus stream and are
// checked against a reference that derives lamp patterns from time spent in the current mode.
module tb_tail_light_seq;
  logic clk;
  logic rst_n;
  logic emg, lft, rgt, brk;

  int n_checks;
  int n_fail;

  // reference state: current mode, cycles since mode entry, registered brake
  int unsigned m_mode;
  int unsigned m_elapsed;
  logic        m_brake;

  tail_light_seq_if #(.N_LED(3)) if0 ();
  tail_light_seq_if #(.N_LED(4)) if1 ();
  tail_light_seq_if #(.N_LED(3)) if2 ();

  assign if0.emergency = emg; assign if0.left = lft; assign if0.right = rgt; assign if0.brake = brk;
  assign if1.emergency = emg; assign if1.left = lft; assign if1.right = rgt; assign if1.brake = brk;
  assign if2.emergency = emg; assign if2.left = lft; assign if2.right = rgt; assign if2.brake = brk;

  tail_light_seq #(.N_LED(3), .STEP_DIV(1)) u0 (.clk(clk), .reset(rst_n), .bus(if0));
  tail_light_seq #(.N_LED(4), .STEP_DIV(3)) u1 (.clk(clk), .reset(rst_n), .bus(if1));
  tail_light_seq #(.N_LED(3), .STEP_DIV(2)) u2 (.clk(clk), .reset(rst_n), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] therm(input int unsigned k);
    logic [31:0] t;
    t = (32'd1 << k) - 32'd1;
    return t[15:0];
  endfunction

  // side: 0 = left lamps, 1 = right lamps
  function automatic logic [15:0] exp_led(input int unsigned n, input int unsigned sd, input int side);
    logic [15:0] ones;
    ones = therm(n);
    case (m_mode)
      1: return (side == 0) ? therm((m_elapsed / sd) % (n + 1)) : (m_brake ? ones : 16'h0);
      2: return (side == 1) ? therm((m_elapsed / sd) % (n + 1)) : (m_brake ? ones : 16'h0);
      3: return ((m_elapsed / sd) % 2 == 0) ? ones : 16'h0;
      default: return m_brake ? ones : 16'h0;
    endcase
  endfunction

  task automatic check_all(input string when);
    check({when, " u0.mode"}, 16'(if0.mode), 16'(m_mode));
    check({when, " u0.left"}, 16'(if0.led_left), exp_led(3, 1, 0));
    check({when, " u0.right"}, 16'(if0.led_right), exp_led(3, 1, 1));
    check({when, " u1.mode"}, 16'(if1.mode), 16'(m_mode));
    check({when, " u1.left"}, 16'(if1.led_left), exp_led(4, 3, 0));
    check({when, " u1.right"}, 16'(if1.led_right), exp_led(4, 3, 1));
    check({when, " u2.mode"}, 16'(if2.mode), 16'(m_mode));
    check({when, " u2.left"}, 16'(if2.led_left), exp_led(3, 2, 0));
    check({when, " u2.right"}, 16'(if2.led_right), exp_led(3, 2, 1));
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_elapsed = 0;
    m_brake   = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned nm;
    if (emg)              nm = 3;
    else if (lft && !rgt) nm = 1;
    else if (rgt && !lft) nm = 2;
    else                  nm = 0;
    if (nm != m_mode) m_elapsed = 0;
    else              m_elapsed++;
    m_mode  = nm;
    m_brake = brk;
  endtask

  // Hold one input combination for len edges, optionally preceded by an
  // asynchronous reset pulse asserted between clock edges.
  task automatic run_seg(input logic e, input logic l, input logic r, input logic b,
                         input int unsigned len, input bit rst_first);
    @(negedge clk);
    if (rst_first) begin
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      #1 check_all("in_rst");
      @(negedge clk);
      rst_n = 1'b1;
    end
    emg = e; lft = l; rgt = r; brk = b;
    for (int unsigned i = 0; i < len; i++) begin
      if (i != 0) @(negedge clk);
      @(posedge clk);
      model_edge();
      #1 check_all("run");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    emg = 1'b0; lft = 1'b0; rgt = 1'b0; brk = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #3 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_seg(1'b0, 1'b1, 1'b0, 1'b0, 10, 1'b0);  // left fill
    run_seg(1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0);  // right fill with brake
    run_seg(1'b1, 1'b1, 1'b0, 1'b1, 12, 1'b0);  // hazard beats turn and brake
    run_seg(1'b0, 1'b1, 1'b0, 1'b1, 6, 1'b0);   // emergency released, left restarts
    run_seg(1'b0, 1'b1, 1'b1, 1'b0, 3, 1'b0);   // illegal combo -> idle
    run_seg(1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    run_seg(1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0);   // mid-fill
    run_seg(1'b0, 1'b0, 1'b1, 1'b0, 5, 1'b0);   // direct switch to right
    run_seg(1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    run_seg(1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b1);   // reset during hazard, release into hazard

    for (int s = 0; s < 150; s++) begin
      logic re, rl, rr, rb;
      re = ($urandom_range(0, 7) == 0);
      rl = $urandom_range(0, 1) == 1;
      rr = $urandom_range(0, 1) == 1;
      rb = $urandom_range(0, 1) == 1;
      run_seg(re, rl, rr, rb, $urandom_range(1, 25), $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
